// File: rtl/decode_ctrl_queue_if.sv
// Handshake bundle between fetch, the decode-control queue and register read.
// The queue owns the slave side; the producer/consumer side is the master.
interface decode_ctrl_queue_if #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
);
    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  in_pc;
    logic [31:0]                  in_instr;
    logic                         in_bd;
    logic                         out_valid;
    logic                         out_ready;
    logic [31:0]                  out_pc;
    logic [31:0]                  out_instr;
    logic                         out_bd;
    logic [4:0]                   out_dst_addr;
    logic                         out_reg_write;
    logic                         out_exc;
    logic [4:0]                   out_exc_code;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic [CNT_W-1:0]             exc_count;

    modport master (
        output flush, in_valid, in_pc, in_instr, in_bd, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_bd, out_dst_addr,
               out_reg_write, out_exc, out_exc_code, count, exc_count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, in_bd, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_bd, out_dst_addr,
               out_reg_write, out_exc, out_exc_code, count, exc_count
    );
endinterface

// File: rtl/decode_ctrl_queue.sv
// Decode-control stage: decodes dst/reg-write/exceptions at enqueue time and
// buffers the decoded entries in a DEPTH-entry FIFO with flush support.
module decode_ctrl_queue #(
    parameter int unsigned DEPTH   = 2,
    parameter logic [31:0] ADDR_LO = 32'h0000_3000,
    parameter logic [31:0] ADDR_HI = 32'h0000_6ffc,
    parameter bit          EN_CP0  = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input logic                clk,
    input logic                reset_n,
    decode_ctrl_queue_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        logic [4:0]  dst;
        logic        reg_write;
        logic        exc;
        logic [4:0]  exc_code;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           dec_d;
    entry_t           head;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] exc_cnt_q, exc_cnt_d;
    logic             push, pop, in_ready, out_valid;

    logic [5:0] dec_op, dec_fn;
    logic [4:0] dec_rs, dec_rt, dec_rd;
    logic       dec_ri, dec_sys, dec_cp0, dec_adel;

    assign dec_op   = bus.in_instr[31:26];
    assign dec_rs   = bus.in_instr[25:21];
    assign dec_rt   = bus.in_instr[20:16];
    assign dec_rd   = bus.in_instr[15:11];
    assign dec_fn   = bus.in_instr[5:0];
    assign dec_adel = (bus.in_pc[1:0] != 2'b00) || (bus.in_pc < ADDR_LO) || (bus.in_pc > ADDR_HI);

    always_comb begin
        dec_d       = '0;
        dec_d.pc    = bus.in_pc;
        dec_d.instr = bus.in_instr;
        dec_d.bd    = bus.in_bd;
        dec_ri      = 1'b0;
        dec_sys     = 1'b0;
        dec_cp0     = 1'b0;
        case (dec_op)
            6'h00: begin
                case (dec_fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2a: begin
                        dec_d.dst       = dec_rd;
                        dec_d.reg_write = 1'b1;
                    end
                    6'h08:   dec_d.reg_write = 1'b0;
                    6'h0c:   dec_sys = 1'b1;
                    default: dec_ri  = 1'b1;
                endcase
            end
            6'h08, 6'h0d, 6'h0f, 6'h23: begin
                dec_d.dst       = dec_rt;
                dec_d.reg_write = 1'b1;
            end
            6'h03: begin
                dec_d.dst       = 5'd31;
                dec_d.reg_write = 1'b1;
            end
            6'h2b, 6'h04: dec_d.reg_write = 1'b0;
            6'h10: begin
                dec_cp0 = 1'b1;
                if (dec_rs == 5'h00) begin
                    dec_d.dst       = dec_rt;
                    dec_d.reg_write = 1'b1;
                end else if (dec_rs == 5'h04) begin
                    dec_d.reg_write = 1'b0;
                end else if (!(dec_rs == 5'h10 && dec_fn == 6'h18)) begin
                    dec_ri = 1'b1;
                end
            end
            default: dec_ri = 1'b1;
        endcase
        if (dec_cp0 && !EN_CP0) begin
            dec_ri = 1'b1;
        end
        // Exception priority: address error masks everything about the word.
        if (dec_adel) begin
            dec_d.instr     = '0;
            dec_d.dst       = '0;
            dec_d.reg_write = 1'b0;
            dec_d.exc       = 1'b1;
            dec_d.exc_code  = 5'd4;
        end else if (dec_ri) begin
            dec_d.dst       = '0;
            dec_d.reg_write = 1'b0;
            dec_d.exc       = 1'b1;
            dec_d.exc_code  = 5'd10;
        end else if (dec_sys) begin
            dec_d.exc       = 1'b1;
            dec_d.exc_code  = 5'd8;
        end
        if (dec_d.dst == 5'd0) begin
            dec_d.reg_write = 1'b0;
        end
    end

    assign out_valid = (count_q != '0);
    assign in_ready  = (32'(count_q) < DEPTH) && !bus.flush;
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready && !bus.flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        exc_cnt_d = exc_cnt_q;
        if (push && dec_d.exc && (exc_cnt_q != '1)) begin
            exc_cnt_d = exc_cnt_q + CNT_W'(1);
        end
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            exc_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            exc_cnt_q <= exc_cnt_d;
        end
    end

    // Storage needs no reset: the output mux below hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec_d;
        end
    end

    assign head              = mem_q[rd_ptr_q];
    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_pc        = out_valid ? head.pc        : '0;
    assign bus.out_instr     = out_valid ? head.instr     : '0;
    assign bus.out_bd        = out_valid ? head.bd        : 1'b0;
    assign bus.out_dst_addr  = out_valid ? head.dst       : '0;
    assign bus.out_reg_write = out_valid ? head.reg_write : 1'b0;
    assign bus.out_exc       = out_valid ? head.exc       : 1'b0;
    assign bus.out_exc_code  = out_valid ? head.exc_code  : '0;
    assign bus.count         = count_q;
    assign bus.exc_count     = exc_cnt_q;
endmodule

// File: tb/tb_decode_ctrl_queue.sv
// Bench for decode_ctrl_queue: two instances (CP0 enabled/disabled) share one
// stimulus stream and are checked every cycle against a queue-based model.
module tb_decode_ctrl_queue;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    decode_ctrl_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) ba ();
    decode_ctrl_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bb ();

    decode_ctrl_queue #(.DEPTH(DEPTH), .EN_CP0(1'b1), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ba.slave));
    decode_ctrl_queue #(.DEPTH(DEPTH), .EN_CP0(1'b0), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bb.slave));

    assign bb.flush     = ba.flush;
    assign bb.in_valid  = ba.in_valid;
    assign bb.in_pc     = ba.in_pc;
    assign bb.in_instr  = ba.in_instr;
    assign bb.in_bd     = ba.in_bd;
    assign bb.out_ready = ba.out_ready;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        logic [4:0]  dst;
        logic        rw;
        logic        exc;
        logic [4:0]  code;
    } ent_t;

    typedef struct {
        ent_t a;
        ent_t b;
    } pair_t;

    pair_t            mq[$];
    logic [CNT_W-1:0] mex_a = '0;
    logic [CNT_W-1:0] mex_b = '0;
    int               n_chk = 0;
    int               n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t model_entry(input logic [31:0] pc, input logic [31:0] instr,
                                         input logic bd, input bit en_cp0);
        ent_t       e;
        logic [5:0] op = instr[31:26];
        logic [5:0] fn = instr[5:0];
        logic [4:0] rs = instr[25:21];
        logic [4:0] rt = instr[20:16];
        logic [4:0] rd = instr[15:11];
        bit         legal = 1'b1;
        bit         is_cp0 = 1'b0;
        bit         is_sys = 1'b0;
        logic [4:0] dst = 5'd0;
        bit         wr = 1'b0;
        if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) begin
            dst = rd; wr = 1'b1;
        end else if (op inside {6'h08, 6'h0d, 6'h0f, 6'h23}) begin
            dst = rt; wr = 1'b1;
        end else if (op == 6'h10 && rs == 5'd0) begin
            dst = rt; wr = 1'b1; is_cp0 = 1'b1;
        end else if (op == 6'h03) begin
            dst = 5'd31; wr = 1'b1;
        end else if (op == 6'h00 && fn == 6'h0c) begin
            is_sys = 1'b1;
        end else if ((op == 6'h00 && fn == 6'h08) || op inside {6'h2b, 6'h04}) begin
            wr = 1'b0;
        end else if (op == 6'h10 && (rs == 5'd4 || (rs == 5'h10 && fn == 6'h18))) begin
            is_cp0 = 1'b1;
        end else begin
            legal = 1'b0;
        end
        if (is_cp0 && !en_cp0) legal = 1'b0;
        e.pc = pc; e.bd = bd; e.instr = instr; e.exc = 1'b0; e.code = 5'd0;
        if (pc[1:0] != 2'b00 || pc < 32'h3000 || pc > 32'h6ffc) begin
            e.instr = '0; dst = 5'd0; wr = 1'b0; e.exc = 1'b1; e.code = 5'd4;
        end else if (!legal) begin
            dst = 5'd0; wr = 1'b0; e.exc = 1'b1; e.code = 5'd10;
        end else if (is_sys) begin
            e.exc = 1'b1; e.code = 5'd8;
        end
        if (dst == 5'd0) wr = 1'b0;
        e.dst = dst;
        e.rw  = wr;
        return e;
    endfunction

    // Reference model: occupancy is the queue length, head is mq[0].
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            mex_a = '0;
            mex_b = '0;
        end else begin
            bit    enq, deq;
            pair_t p;
            deq = (mq.size() != 0) && ba.out_ready && !ba.flush;
            enq = ba.in_valid && !ba.flush && (mq.size() < DEPTH);
            if (ba.flush) begin
                mq.delete();
            end else begin
                if (deq) void'(mq.pop_front());
                if (enq) begin
                    p.a = model_entry(ba.in_pc, ba.in_instr, ba.in_bd, 1'b1);
                    p.b = model_entry(ba.in_pc, ba.in_instr, ba.in_bd, 1'b0);
                    mq.push_back(p);
                    if (p.a.exc && mex_a != '1) mex_a = mex_a + 1'b1;
                    if (p.b.exc && mex_b != '1) mex_b = mex_b + 1'b1;
                end
            end
        end
    end

    task automatic cmp_head(input string t, input bit v, input ent_t e, input logic ov,
                            input logic [31:0] pc, input logic [31:0] ins, input logic bd,
                            input logic [4:0] dst, input logic rw, input logic exc,
                            input logic [4:0] code);
        ent_t z;
        z = '{pc: 32'd0, instr: 32'd0, bd: 1'b0, dst: 5'd0, rw: 1'b0, exc: 1'b0, code: 5'd0};
        if (!v) e = z;
        chk({t, ".out_valid"}, 32'(ov), 32'(v));
        chk({t, ".out_pc"}, pc, e.pc);
        chk({t, ".out_instr"}, ins, e.instr);
        chk({t, ".out_bd"}, 32'(bd), 32'(e.bd));
        chk({t, ".out_dst"}, 32'(dst), 32'(e.dst));
        chk({t, ".out_reg_write"}, 32'(rw), 32'(e.rw));
        chk({t, ".out_exc"}, 32'(exc), 32'(e.exc));
        chk({t, ".out_exc_code"}, 32'(code), 32'(e.code));
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            bit    v;
            pair_t h;
            v = (mq.size() != 0);
            if (v) h = mq[0];
            cmp_head("A", v, h.a, ba.out_valid, ba.out_pc, ba.out_instr, ba.out_bd,
                     ba.out_dst_addr, ba.out_reg_write, ba.out_exc, ba.out_exc_code);
            cmp_head("B", v, h.b, bb.out_valid, bb.out_pc, bb.out_instr, bb.out_bd,
                     bb.out_dst_addr, bb.out_reg_write, bb.out_exc, bb.out_exc_code);
            chk("A.count", 32'(ba.count), 32'(mq.size()));
            chk("B.count", 32'(bb.count), 32'(mq.size()));
            chk("A.in_ready", 32'(ba.in_ready), 32'((mq.size() < DEPTH) && !ba.flush));
            chk("B.in_ready", 32'(bb.in_ready), 32'((mq.size() < DEPTH) && !ba.flush));
            chk("A.exc_count", 32'(ba.exc_count), 32'(mex_a));
            chk("B.exc_count", 32'(bb.exc_count), 32'(mex_b));
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic bd, input logic rdy, input logic fl);
        ba.in_valid  = v;
        ba.in_pc     = pc;
        ba.in_instr  = ins;
        ba.in_bd     = bd;
        ba.out_ready = rdy;
        ba.flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push1(input logic [31:0] pc, input logic [31:0] ins);
        drive(1'b1, pc, ins, 1'b0, 1'b0, 1'b0);
        step();
        idle();
    endtask

    task automatic pop1();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        step();
        idle();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  op_tab [7];
        logic [5:0]  fn_tab [7];
        logic [4:0]  rs_tab [4];
        op_tab = '{6'h08, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h03};
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08, 6'h0c};
        rs_tab = '{5'h00, 5'h04, 5'h10, 5'h07};
        w = $urandom();
        case ($urandom_range(0, 4))
            0: begin w[31:26] = 6'h00; w[5:0] = fn_tab[$urandom_range(0, 6)]; end
            1: w[31:26] = op_tab[$urandom_range(0, 6)];
            2: begin
                w[31:26] = 6'h10;
                w[25:21] = rs_tab[$urandom_range(0, 3)];
                if ($urandom_range(0, 1) == 0) w[5:0] = 6'h18;
            end
            3: w[20:11] = '0;
            default: w = w;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        case ($urandom_range(0, 9))
            0: p = 32'h2ffc;
            1: p = 32'h7000;
            2: p = 32'h6ffc;
            3: p = 32'h3000 + 32'($urandom_range(1, 3));
            4: p = $urandom();
            default: p = 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
        endcase
        return p;
    endfunction

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.count", 32'(ba.count), 32'd0);
        chk("rst.out_valid", 32'(ba.out_valid), 32'd0);
        chk("rst.exc_count", 32'(ba.exc_count), 32'd0);
        chk("rst.out_pc", ba.out_pc, 32'd0);
        reset_n = 1'b1;
        step();

        push1(32'h3000, 32'h012A4020);
        chk("add.out_valid", 32'(ba.out_valid), 32'd1);
        chk("add.dst", 32'(ba.out_dst_addr), 32'd8);
        chk("add.reg_write", 32'(ba.out_reg_write), 32'd1);
        chk("add.exc", 32'(ba.out_exc), 32'd0);
        chk("add.count", 32'(ba.count), 32'd1);
        pop1();

        push1(32'h3002, 32'h012A4020);
        chk("adel_mis.exc", 32'(ba.out_exc), 32'd1);
        chk("adel_mis.code", 32'(ba.out_exc_code), 32'd4);
        chk("adel_mis.instr", ba.out_instr, 32'd0);
        chk("adel_mis.reg_write", 32'(ba.out_reg_write), 32'd0);
        chk("adel_mis.exc_count", 32'(ba.exc_count), 32'd1);
        pop1();
        push1(32'h7000, 32'h012A4020);
        chk("adel_hi.code", 32'(ba.out_exc_code), 32'd4);
        chk("adel_hi.exc_count", 32'(ba.exc_count), 32'd2);
        pop1();
        push1(32'h2ffc, 32'h012A4020);
        chk("adel_lo.code", 32'(ba.out_exc_code), 32'd4);
        pop1();

        push1(32'h3004, 32'hFC000000);
        chk("ri.code", 32'(ba.out_exc_code), 32'd10);
        pop1();
        push1(32'h3008, 32'h0000000C);
        chk("sys.code", 32'(ba.out_exc_code), 32'd8);
        chk("sys.exc_count", 32'(ba.exc_count), 32'd5);
        pop1();
        push1(32'h300c, 32'h40086000);
        chk("mfc0_en.dst", 32'(ba.out_dst_addr), 32'd8);
        chk("mfc0_en.exc", 32'(ba.out_exc), 32'd0);
        chk("mfc0_dis.code", 32'(bb.out_exc_code), 32'd10);
        chk("mfc0_dis.exc_count", 32'(bb.exc_count), 32'd6);
        pop1();

        drive(1'b1, 32'h3010, 32'h012A4020, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h3014, 32'h012A4020, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h3018, 32'h012A4020, 1'b0, 1'b0, 1'b0);
        chk("full.in_ready", 32'(ba.in_ready), 32'd0);
        step();
        chk("full.count", 32'(ba.count), 32'd2);
        chk("full.head_pc", ba.out_pc, 32'h3010);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h3020 + 32'(i * 4), 32'h01095020 + 32'(i << 11), 1'(i), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        step();
        step();

        push1(32'h3040, 32'h012A4020);
        push1(32'h3001, 32'h012A4020);
        drive(1'b1, 32'h3044, 32'h0000000C, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        chk("flush.count", 32'(ba.count), 32'd0);
        chk("flush.out_valid", 32'(ba.out_valid), 32'd0);
        chk("flush.exc_count_a", 32'(ba.exc_count), 32'd6);
        chk("flush.exc_count_b", 32'(bb.exc_count), 32'd7);
        step();

        push1(32'h3048, 32'h012A4020);
        push1(32'h304c, 32'h012A4020);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(ba.out_valid), 32'd0);
        chk("arst.count", 32'(ba.count), 32'd0);
        chk("arst.exc_count", 32'(ba.exc_count), 32'd0);
        chk("arst.exc_count_b", 32'(bb.exc_count), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        push1(32'h3000, 32'h0C000C00);
        chk("jal.dst", 32'(ba.out_dst_addr), 32'd31);
        chk("jal.reg_write", 32'(ba.out_reg_write), 32'd1);
        pop1();

        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_pc(), rand_instr(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 19) == 0));
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
